// File: rtl/bbox_pkg.sv
// Shared widths, FSM state type and bounding-box record for the binary bbox tracker.
package bbox_pkg;

  localparam int unsigned XW_DEF   = 12;
  localparam int unsigned YW_DEF   = 12;
  localparam int unsigned CNTW_DEF = 22;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  typedef struct packed {
    logic [XW_DEF-1:0]   xmin;
    logic [XW_DEF-1:0]   xmax;
    logic [YW_DEF-1:0]   ymin;
    logic [YW_DEF-1:0]   ymax;
    logic [CNTW_DEF-1:0] count;
  } bbox_t;

endpackage

// File: rtl/bbox_accum.sv
// Min/max x,y and saturating foreground-count accumulator with clear, seed and enable.
module bbox_accum
  import bbox_pkg::*;
#(
  parameter int unsigned XW   = XW_DEF,
  parameter int unsigned YW   = YW_DEF,
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            seed,
  input  logic            en,
  input  logic [XW-1:0]   x,
  input  logic [YW-1:0]   y,
  output logic [XW-1:0]   xmin,
  output logic [XW-1:0]   xmax,
  output logic [YW-1:0]   ymin,
  output logic [YW-1:0]   ymax,
  output logic [CNTW-1:0] count
);

  logic [XW-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNTW-1:0] count_q, count_d;

  always_comb begin
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    count_d = count_q;
    if (clear) begin
      // Seeding lets a pixel coincident with the frame edge open the new frame.
      if (seed) begin
        xmin_d  = x;
        xmax_d  = x;
        ymin_d  = y;
        ymax_d  = y;
        count_d = CNTW'(1);
      end else begin
        xmin_d  = '1;
        xmax_d  = '0;
        ymin_d  = '1;
        ymax_d  = '0;
        count_d = '0;
      end
    end else if (en) begin
      if (x < xmin_q) xmin_d = x;
      if (x > xmax_q) xmax_d = x;
      if (y < ymin_q) ymin_d = y;
      if (y > ymax_q) ymax_d = y;
      if (count_q != '1) count_d = count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmin_q  <= '1;
      xmax_q  <= '0;
      ymin_q  <= '1;
      ymax_q  <= '0;
      count_q <= '0;
    end else begin
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      count_q <= count_d;
    end
  end

  assign xmin  = xmin_q;
  assign xmax  = xmax_q;
  assign ymin  = ymin_q;
  assign ymax  = ymax_q;
  assign count = count_q;

endmodule

// File: rtl/binary_bbox_tracker.sv
// Per-frame foreground bounding box tracker with a 1-clk video pass-through.
// Define BBOX_OVERLAY_EN to outline the published box on o_data in BOX_COLOR.
module binary_bbox_tracker
  import bbox_pkg::*;
#(
  parameter int unsigned XW         = XW_DEF,
  parameter int unsigned YW         = YW_DEF,
  parameter int unsigned CNTW       = CNTW_DEF,
  parameter int unsigned MIN_PIXELS = 16,
`ifdef BBOX_OVERLAY_EN
  parameter logic [23:0] BOX_COLOR  = 24'hFF0000,
`endif
  parameter logic        VS_POL     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_hs,
  input  logic            i_vs,
  input  logic            i_de,
  input  logic [XW-1:0]   i_x,
  input  logic [YW-1:0]   i_y,
  input  logic            i_flag,
  input  logic [23:0]     i_data,
  output logic            o_hs,
  output logic            o_vs,
  output logic            o_de,
  output logic [XW-1:0]   o_x,
  output logic [YW-1:0]   o_y,
  output logic [23:0]     o_data,
  output logic            box_valid,
  output logic [XW-1:0]   box_xmin,
  output logic [XW-1:0]   box_xmax,
  output logic [YW-1:0]   box_ymin,
  output logic [YW-1:0]   box_ymax,
  output logic [CNTW-1:0] pix_count,
  output logic            frame_done
);

  state_e          state_q, state_d;
  logic            vs_d1_q, vs_edge, pixel_hit;
  logic            acc_clear, acc_seed, acc_en, publish;
  logic [XW-1:0]   acc_xmin, acc_xmax;
  logic [YW-1:0]   acc_ymin, acc_ymax;
  logic [CNTW-1:0] acc_count;
  logic [23:0]     o_data_d;

  assign vs_edge   = (i_vs == VS_POL) && (vs_d1_q != VS_POL);
  assign pixel_hit = i_de && i_flag;

  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_seed  = 1'b0;
    acc_en    = 1'b0;
    publish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (vs_edge) begin
          acc_clear = 1'b1;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (vs_edge) begin
          publish   = 1'b1;
          acc_clear = 1'b1;
          acc_seed  = pixel_hit;
        end else begin
          acc_en = pixel_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  bbox_accum #(
    .XW   (XW),
    .YW   (YW),
    .CNTW (CNTW)
  ) u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (acc_clear),
    .seed  (acc_seed),
    .en    (acc_en),
    .x     (i_x),
    .y     (i_y),
    .xmin  (acc_xmin),
    .xmax  (acc_xmax),
    .ymin  (acc_ymin),
    .ymax  (acc_ymax),
    .count (acc_count)
  );

`ifdef BBOX_OVERLAY_EN
  logic in_xr, in_yr, on_col, on_row;
  always_comb begin
    in_xr    = (i_x >= box_xmin) && (i_x <= box_xmax);
    in_yr    = (i_y >= box_ymin) && (i_y <= box_ymax);
    on_col   = ((i_x == box_xmin) || (i_x == box_xmax)) && in_yr;
    on_row   = ((i_y == box_ymin) || (i_y == box_ymax)) && in_xr;
    o_data_d = (box_valid && i_de && (on_col || on_row)) ? BOX_COLOR : i_data;
  end
`else
  always_comb begin
    o_data_d = i_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vs_d1_q    <= ~VS_POL;
      o_hs       <= 1'b0;
      o_vs       <= 1'b0;
      o_de       <= 1'b0;
      o_x        <= '0;
      o_y        <= '0;
      o_data     <= '0;
      box_valid  <= 1'b0;
      box_xmin   <= '0;
      box_xmax   <= '0;
      box_ymin   <= '0;
      box_ymax   <= '0;
      pix_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_d1_q    <= i_vs;
      o_hs       <= i_hs;
      o_vs       <= i_vs;
      o_de       <= i_de;
      o_x        <= i_x;
      o_y        <= i_y;
      o_data     <= o_data_d;
      frame_done <= publish;
      if (publish) begin
        box_valid <= (acc_count >= CNTW'(MIN_PIXELS));
        box_xmin  <= acc_xmin;
        box_xmax  <= acc_xmax;
        box_ymin  <= acc_ymin;
        box_ymax  <= acc_ymax;
        pix_count <= acc_count;
      end
    end
  end

endmodule

// File: tb/tb_binary_bbox_tracker.sv
// Directed self-checking bench for binary_bbox_tracker on 16x8 frames.
module tb_binary_bbox_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0, i_flag = 1'b0;
  logic [11:0] i_x = '0, i_y = '0;
  logic [23:0] i_data = '0;
  logic        o_hs, o_vs, o_de, box_valid, frame_done;
  logic [11:0] o_x, o_y, box_xmin, box_xmax, box_ymin, box_ymax;
  logic [23:0] o_data;
  logic [21:0] pix_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned fd_cnt = 0;
  int unsigned fd_base;

  logic        chk_pipe = 1'b0;
  logic        prev_hs = 1'b0, prev_vs = 1'b0, prev_de = 1'b0;
  logic [11:0] prev_x = '0, prev_y = '0;
  logic [23:0] prev_data = '0;
  logic        mdl_valid = 1'b0;
  int          mx0 = 0, mx1 = 0, my0 = 0, my1 = 0;

  binary_bbox_tracker #(
    .MIN_PIXELS (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hs       (i_hs),
    .i_vs       (i_vs),
    .i_de       (i_de),
    .i_x        (i_x),
    .i_y        (i_y),
    .i_flag     (i_flag),
    .i_data     (i_data),
    .o_hs       (o_hs),
    .o_vs       (o_vs),
    .o_de       (o_de),
    .o_x        (o_x),
    .o_y        (o_y),
    .o_data     (o_data),
    .box_valid  (box_valid),
    .box_xmin   (box_xmin),
    .box_xmax   (box_xmax),
    .box_ymin   (box_ymin),
    .box_ymax   (box_ymax),
    .pix_count  (pix_count),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_data(input int x, input int y, input logic de, input logic [23:0] d);
    logic border;
    border = (((x == mx0) || (x == mx1)) && (y >= my0) && (y <= my1)) ||
             (((y == my0) || (y == my1)) && (x >= mx0) && (x <= mx1));
`ifdef BBOX_OVERLAY_EN
    return (mdl_valid && de && border) ? 24'hFF0000 : d;
`else
    return (border && 1'b0) ? 24'hFF0000 : d;
`endif
  endfunction

  // One clock of stimulus; optionally checks the previous clock's inputs emerged on o_*.
  task automatic drive(input logic hs, input logic vs, input logic de, input logic flag,
                       input int x, input int y);
    logic [11:0] xv, yv;
    @(negedge clk);
    if (chk_pipe) begin
      check_eq("pipe_sync_pos", {o_hs, o_vs, o_de, o_x, o_y},
               {prev_hs, prev_vs, prev_de, prev_x, prev_y});
      check_eq("pipe_data", o_data, exp_data(prev_x, prev_y, prev_de, prev_data));
      if (prev_de && prev_x == 3 && prev_y == 2)
`ifdef BBOX_OVERLAY_EN
        check_eq("ovl_3_2", o_data, 24'hFF0000);
`else
        check_eq("ovl_3_2", o_data, 24'h002003);
`endif
      if (prev_de && prev_x == 5 && prev_y == 3)
`ifdef BBOX_OVERLAY_EN
        check_eq("ovl_5_3", o_data, 24'hFF0000);
`else
        check_eq("ovl_5_3", o_data, 24'h003005);
`endif
      if (prev_de && prev_x == 4 && prev_y == 4)
`ifdef BBOX_OVERLAY_EN
        check_eq("ovl_4_4", o_data, 24'hFF0000);
`else
        check_eq("ovl_4_4", o_data, 24'h004004);
`endif
      if (prev_de && prev_x == 4 && prev_y == 3) check_eq("ovl_4_3", o_data, 24'h003004);
      if (prev_de && prev_x == 6 && prev_y == 2) check_eq("ovl_6_2", o_data, 24'h002006);
    end
    xv = 12'(x);
    yv = 12'(y);
    i_hs = hs; i_vs = vs; i_de = de; i_flag = flag;
    i_x = xv; i_y = yv; i_data = {yv, xv};
    prev_hs = hs; prev_vs = vs; prev_de = de;
    prev_x = xv; prev_y = yv; prev_data = {yv, xv};
  endtask

  task automatic vs_pulse();
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  // 16x8 active area; flag set inside [x0..x1]x[y0..y1]; flag=1 with de=0 in blanking.
  task automatic pixels(input int x0, input int x1, input int y0, input int y1, input int rows);
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < 16; x++)
        drive(1'b0, 1'b0, 1'b1, (x >= x0 && x <= x1 && y >= y0 && y <= y1), x, y);
      repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b1, 9, y);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_box(input string tag, input int fd_exp, input logic [11:0] x0,
                           input logic [11:0] x1, input logic [11:0] y0, input logic [11:0] y1,
                           input logic [21:0] cnt, input logic vld);
    check_eq({tag, "_frame_done"}, 64'(fd_cnt), 64'(fd_exp));
    check_eq({tag, "_box"}, {box_xmin, box_xmax, box_ymin, box_ymax}, {x0, x1, y0, y1});
    check_eq({tag, "_count"}, 64'(pix_count), 64'(cnt));
    check_eq({tag, "_valid"}, 64'(box_valid), 64'(vld));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {o_hs, o_vs, o_de, o_x, o_y, o_data, box_valid, box_xmin, box_xmax,
              box_ymin, box_ymax, pix_count, frame_done}, '0);
    rst_n = 1'b1;

    // Small 9-pixel box, below MIN_PIXELS
    vs_pulse();
    check_eq("first_edge_no_done", 64'(fd_cnt), 64'd0);
    pixels(3, 5, 2, 4, 8);
    vs_pulse();
    check_box("t1_f1", 1, 12'd3, 12'd5, 12'd2, 12'd4, 22'd9, 1'b0);
    pixels(3, 5, 2, 4, 8);
    vs_pulse();
    check_box("t1_f2", 2, 12'd3, 12'd5, 12'd2, 12'd4, 22'd9, 1'b0);

    // 32-pixel box, valid
    pixels(0, 7, 0, 3, 8);
    vs_pulse();
    check_box("t2", 3, 12'd0, 12'd7, 12'd0, 12'd3, 22'd32, 1'b1);

    // Empty frame publishes the clear values
    pixels(15, 0, 0, 0, 8);
    vs_pulse();
    check_box("t3", 4, 12'hFFF, 12'd0, 12'hFFF, 12'd0, 22'd0, 1'b0);

    // Asynchronous reset in the middle of a frame
    pixels(3, 5, 2, 4, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midframe_reset_outputs",
             {o_hs, o_vs, o_de, o_x, o_y, o_data, box_valid, box_xmin, box_xmax,
              box_ymin, box_ymax, pix_count, frame_done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    fd_base = fd_cnt;
    vs_pulse();
    check_eq("reset_first_edge_no_done", 64'(fd_cnt), 64'(fd_base));
    pixels(1, 2, 1, 6, 8);
    vs_pulse();
    check_box("t5", int'(fd_base) + 1, 12'd1, 12'd2, 12'd1, 12'd6, 22'd12, 1'b0);

    // 3x3 box fed twice within one frame -> 18 pixels, valid
    pixels(3, 5, 2, 4, 8);
    pixels(3, 5, 2, 4, 8);
    vs_pulse();
    check_box("t6_pub", int'(fd_base) + 2, 12'd3, 12'd5, 12'd2, 12'd4, 22'd18, 1'b1);

    // Latency / overlay frame against the published (3,5,2,4) box
    mdl_valid = 1'b1; mx0 = 3; mx1 = 5; my0 = 2; my1 = 4;
    chk_pipe = 1'b1;
    pixels(3, 5, 2, 4, 8);
    vs_pulse();
    chk_pipe = 1'b0;
    check_box("t6_next", int'(fd_base) + 3, 12'd3, 12'd5, 12'd2, 12'd4, 22'd9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
